// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle mul/div sequencer.
//   state_e : controller FSM states
//   op_e    : operation captured at issue
//   IterCount / CntWidth : iteration count and the width of its down-counter
//   ExcCodeMul / ExcCodeDiv : rstatus codes written on mul overflow / div fault
//   abs_val : two's-complement magnitude (0x80000000 maps to itself, read as unsigned 2^31)
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef enum logic {
    OpMul,
    OpDiv
  } op_e;

  localparam int unsigned IterCount = 32;
  localparam int unsigned CntWidth  = 5;

  localparam logic [31:0] ExcCodeMul = 32'd4;
  localparam logic [31:0] ExcCodeDiv = 32'd5;

  function automatic logic [31:0] abs_val(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_iter.sv
// Shift/add/subtract datapath for the mul/div sequencer. One iteration per cycle while step_i.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears all datapath registers)
//   load_i        : capture operands for a new op (op_i selects how)
//   step_i        : advance one Booth (mul) or restoring-division (div) iteration
//   op_i          : operation; the controller drives the issuing op during load and the
//                   captured op while stepping
//   a_i, b_i      : multiplicand/dividend and multiplier/divisor
//   prod_nxt_o    : {hi[31:0], lo} as it will be after the current step. After the final step
//                   this is the 64-bit product (mul) or holds the quotient magnitude in [31:0] (div)
module multdiv_iter
  import multdiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  op_e         op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_nxt_o
);

  // hi: Booth partial product (33 bits so subtracting -2^31 cannot wrap) or remainder.
  // lo: multiplier bits being shifted out, or dividend bits shifted out / quotient shifted in.
  logic [32:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] m_q, m_d;
  logic        qm1_q, qm1_d;

  logic [32:0] step_hi;
  logic [31:0] step_lo;
  logic        step_qm1;
  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;

  always_comb begin
    booth_sum = hi_q;
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + {m_q[31], m_q};
      2'b10:   booth_sum = hi_q - {m_q[31], m_q};
      default: booth_sum = hi_q;
    endcase

    div_shift = {hi_q[31:0], lo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, m_q};

    if (op_i == OpMul) begin
      // Arithmetic right shift of {sum, lo, q-1}.
      step_hi  = {booth_sum[32], booth_sum[32:1]};
      step_lo  = {booth_sum[0], lo_q[31:1]};
      step_qm1 = lo_q[0];
    end else begin
      step_qm1 = qm1_q;
      if (!div_diff[33]) begin
        step_hi = div_diff[32:0];
        step_lo = {lo_q[30:0], 1'b1};
      end else begin
        step_hi = div_shift;
        step_lo = {lo_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    m_d   = m_q;
    qm1_d = qm1_q;
    if (load_i) begin
      hi_d  = '0;
      qm1_d = 1'b0;
      if (op_i == OpMul) begin
        lo_d = b_i;
        m_d  = a_i;
      end else begin
        lo_d = abs_val(a_i);
        m_d  = abs_val(b_i);
      end
    end else if (step_i) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      qm1_d = step_qm1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      qm1_q <= qm1_d;
    end
  end

  assign prod_nxt_o = {step_hi[31:0], step_lo};

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle mul/div path of the execute stage.
// Captures a mul/div issue from X, runs 32 signed iterations in multdiv_iter, stalls the front
// of the pipeline meanwhile, and presents the result (or an rstatus code with write_exception)
// for the X/M latch with a one-cycle result_valid pulse.
//   clock, reset     : clock, synchronous active-low reset
//   start_mul/div    : mul/div insn in X (mul wins if both)
//   operandA/B       : bypassed rs/rt
//   dest_in          : destination register of the issuing insn
//   flush            : kill the in-flight op
//   stall            : hold PC, F/D, D/X; bubble into X/M
//   busy             : FSM not idle
//   result_valid     : result/dest_out/write_exception valid this cycle
//   result, dest_out, write_exception : registered, hold their value between ops
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned          WIDTH        = 32,
  parameter logic [WIDTH-1:0]     EXC_CODE_MUL = ExcCodeMul,
  parameter logic [WIDTH-1:0]     EXC_CODE_DIV = ExcCodeDiv
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       dest_in,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       dest_out,
  output logic             write_exception
);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  op_e                 op_q, op_d;
  logic                neg_q, neg_d;
  logic                dovf_q, dovf_d;
  logic [4:0]          dest_q, dest_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [4:0]          dest_out_q, dest_out_d;
  logic                wexc_q, wexc_d;

  op_e         issue_op;
  op_e         iter_op;
  logic        accept;
  logic        div_zero;
  logic        iter_load;
  logic        iter_step;
  logic [63:0] prod_nxt;
  logic        mul_ovf;
  logic [31:0] quot;

  assign issue_op = start_mul ? OpMul : OpDiv;
  assign accept   = (state_q == StIdle) & (start_mul | start_div) & ~flush;
  assign div_zero = (issue_op == OpDiv) & (operandB == '0);

  // Product fits in 32 bits only when bits 63..31 are all copies of the sign.
  assign mul_ovf  = ~(&prod_nxt[63:31]) & (|prod_nxt[63:31]);
  assign quot     = neg_q ? (32'd0 - prod_nxt[31:0]) : prod_nxt[31:0];

  assign iter_load = accept;
  assign iter_step = (state_q == StBusy) & ~flush;
  assign iter_op   = (state_q == StIdle) ? issue_op : op_q;

  multdiv_iter u_iter (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (iter_load),
    .step_i     (iter_step),
    .op_i       (iter_op),
    .a_i        (operandA),
    .b_i        (operandB),
    .prod_nxt_o (prod_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    dovf_d     = dovf_q;
    dest_d     = dest_q;
    result_d   = result_q;
    dest_out_d = dest_out_q;
    wexc_d     = wexc_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = issue_op;
          dest_d = dest_in;
          neg_d  = operandA[31] ^ operandB[31];
          dovf_d = (issue_op == OpDiv) & (operandA == 32'h8000_0000) & (&operandB);
          cnt_d  = CntWidth'(IterCount - 1);
          if (div_zero) begin
            // Nothing to iterate: report the fault on the next cycle.
            state_d    = StDone;
            result_d   = EXC_CODE_DIV;
            wexc_d     = 1'b1;
            dest_out_d = dest_in;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          // Last step: prod_nxt already reflects it, so the result is ready in DONE.
          state_d    = StDone;
          dest_out_d = dest_q;
          if (op_q == OpMul) begin
            result_d = mul_ovf ? EXC_CODE_MUL : prod_nxt[31:0];
            wexc_d   = mul_ovf;
          end else if (dovf_q) begin
            result_d = EXC_CODE_DIV;
            wexc_d   = 1'b1;
          end else begin
            result_d = quot;
            wexc_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= OpMul;
      neg_q      <= 1'b0;
      dovf_q     <= 1'b0;
      dest_q     <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
      wexc_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      dovf_q     <= dovf_d;
      dest_q     <= dest_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
      wexc_q     <= wexc_d;
    end
  end

  assign stall           = accept | (state_q == StBusy);
  assign busy            = (state_q != StIdle);
  assign result_valid    = (state_q == StDone) & ~flush;
  assign result          = result_q;
  assign dest_out        = dest_out_q;
  assign write_exception = wexc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        start_mul;
  logic        start_div;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  dest_in;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  dest_out;
  logic        write_exception;

  int total = 0;
  int bad   = 0;

  multdiv_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .start_mul       (start_mul),
    .start_div       (start_div),
    .operandA        (operandA),
    .operandB        (operandB),
    .dest_in         (dest_in),
    .flush           (flush),
    .stall           (stall),
    .busy            (busy),
    .result_valid    (result_valid),
    .result          (result),
    .dest_out        (dest_out),
    .write_exception (write_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] specials[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain signed arithmetic. Returns {exception, result}.
  function automatic logic [32:0] model(input logic is_mul, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int     q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      if (p != longint'($signed(p[31:0]))) return {1'b1, 32'd4};
      return {1'b0, p[31:0]};
    end
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return {1'b1, 32'd5};
    q = $signed(a) / $signed(b);
    return {1'b0, 32'(q)};
  endfunction

  // Issue at the current cycle T, hold the insn (as a stalled D/X would) through DONE with
  // scrambled operands, check the stall window and the DONE cycle, then drop the start.
  task automatic run_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp_res, input logic exp_exc,
                        input string tag);
    int lat;
    int badc;
    lat       = (!is_mul && b == 32'd0) ? 1 : 33;
    start_mul = is_mul;
    start_div = ~is_mul;
    operandA  = a;
    operandB  = b;
    dest_in   = d;
    @(negedge clock);
    check({tag, " issue_stall"}, 32'(stall), 32'd1);
    check({tag, " issue_busy"}, 32'(busy), 32'd0);
    badc = 0;
    for (int c = 1; c < lat; c++) begin
      next_cycle();
      operandA = $urandom;
      operandB = $urandom;
      dest_in  = 5'($urandom);
      @(negedge clock);
      if (stall !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0) badc++;
    end
    if (lat > 1) check({tag, " busy_window"}, 32'(badc), 32'd0);
    next_cycle();
    @(negedge clock);
    check({tag, " valid"}, 32'(result_valid), 32'd1);
    check({tag, " done_stall"}, 32'(stall), 32'd0);
    check({tag, " result"}, result, exp_res);
    check({tag, " wexc"}, 32'(write_exception), 32'(exp_exc));
    check({tag, " dest"}, 32'(dest_out), 32'(d));
    next_cycle();
    start_mul = 1'b0;
    start_div = 1'b0;
    flush     = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    unique case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 2000)) - 32'd1000;
      default: return specials[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    int          pulses;
    logic [32:0] exp;
    logic        is_mul;
    logic [31:0] a;
    logic [31:0] b;

    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};

    vecs[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFA, 5'd3,  32'hFFFF_FFD6, 1'b0};
    vecs[1]  = '{1'b1, 32'd65536,      32'd65536,     5'd9,  32'd4,         1'b1};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b0, 32'd100,        32'd7,         5'd5,  32'd14,        1'b0};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,         5'd6,  32'd5,         1'b1};
    vecs[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'd5,         1'b1};
    vecs[6]  = '{1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 5'd8,  32'd2,         1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000,  32'd1,         5'd10, 32'h8000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'd4,         1'b1};
    vecs[9]  = '{1'b0, 32'd7,          32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{1'b1, 32'd0,          32'd12345,     5'd13, 32'd0,         1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'd1,         5'd14, 32'h8000_0000, 1'b0};
    vecs[12] = '{1'b1, 32'd46341,      32'd46341,     5'd15, 32'd4,         1'b1};
    vecs[13] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd31, 32'd1,         1'b0};

    reset     = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    flush     = 1'b0;
    operandA  = '0;
    operandB  = '0;
    dest_in   = '0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("rst stall", 32'(stall), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(result_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst dest", 32'(dest_out), 32'd0);
    check("rst wexc", 32'(write_exception), 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Directed table, issued back-to-back (each in the cycle after the previous DONE).
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].is_mul, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp_res,
             vecs[i].exp_exc, $sformatf("vec%0d", i));
    end

    // A start held through DONE must not have been re-accepted there.
    @(negedge clock);
    check("no_accept_in_done busy", 32'(busy), 32'd0);
    check("no_accept_in_done stall", 32'(stall), 32'd0);
    next_cycle();

    // Flush while idle with a start: no issue.
    start_mul = 1'b1;
    operandA  = 32'd3;
    operandB  = 32'd3;
    flush     = 1'b1;
    @(negedge clock);
    check("idle_flush stall", 32'(stall), 32'd0);
    next_cycle();
    start_mul = 1'b0;
    flush     = 1'b0;
    @(negedge clock);
    check("idle_flush busy", 32'(busy), 32'd0);
    next_cycle();

    // Flush at T+10 of a mul; a new mul at T+11 completes at T+44.
    start_mul = 1'b1;
    operandA  = 32'd123;
    operandB  = 32'd456;
    dest_in   = 5'd2;
    pulses    = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 10) flush = 1'b1;
      @(negedge clock);
      if (result_valid) pulses++;
    end
    check("busy_flush stall_at_flush", 32'(stall), 32'd1);
    check("busy_flush pulses", 32'(pulses), 32'd0);
    next_cycle();
    flush = 1'b0;
    run_op(1'b1, 32'd9, 32'd9, 5'd17, 32'd81, 1'b0, "after_flush");

    // Flush in DONE suppresses the pulse.
    start_div = 1'b1;
    operandA  = 32'd100;
    operandB  = 32'd3;
    dest_in   = 5'd20;
    for (int c = 1; c <= 33; c++) next_cycle();
    flush     = 1'b1;
    start_div = 1'b0;
    @(negedge clock);
    check("done_flush valid", 32'(result_valid), 32'd0);
    check("done_flush busy", 32'(busy), 32'd1);
    check("done_flush result", result, 32'd33);
    next_cycle();
    flush = 1'b0;
    @(negedge clock);
    check("done_flush idle", 32'(busy), 32'd0);
    next_cycle();

    // Reset at T+5 of a div.
    start_div = 1'b1;
    operandA  = 32'hFFFF_FF9C;
    operandB  = 32'd7;
    dest_in   = 5'd21;
    for (int c = 1; c <= 5; c++) next_cycle();
    reset     = 1'b0;
    start_div = 1'b0;
    next_cycle();
    @(negedge clock);
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset stall", 32'(stall), 32'd0);
    check("mid_reset result", result, 32'd0);
    check("mid_reset valid", 32'(result_valid), 32'd0);
    check("mid_reset dest", 32'(dest_out), 32'd0);
    next_cycle();
    reset  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      @(negedge clock);
      if (result_valid || busy) pulses++;
    end
    check("post_reset stale", 32'(pulses), 32'd0);
    next_cycle();

    // Randomised ops against the arithmetic model.
    for (int i = 0; i < 50; i++) begin
      is_mul = 1'($urandom_range(0, 1));
      a      = pick_operand();
      b      = pick_operand();
      exp    = model(is_mul, a, b);
      run_op(is_mul, a, b, 5'($urandom), exp[31:0], exp[32], $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
